// File: rtl/edge_pkg.sv
// Shared widths, unpack state encoding and byte-select helper
// for the pixel-stream edge blocks.
package edge_pkg;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;
    localparam int IDX_W        = $clog2(PIX_PER_WORD);

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } unpack_state_t;

    // Slot order is reversed by inverting the 2-bit index.
    function automatic logic [PIX_W-1:0] pick_pix(
        input logic [WORD_W-1:0] w,
        input logic [IDX_W-1:0]  idx,
        input logic              lsb_first
    );
        logic [IDX_W-1:0] slot;
        slot = lsb_first ? idx : ~idx;
        return w[slot*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/line_pos_counter.sv
// Pixel position within an image line; wraps after the last
// pixel of the line.
module line_pos_counter #(
    parameter int LINE_PIXELS = 640,
    parameter int POS_W       = $clog2(LINE_PIXELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [POS_W-1:0] pos,
    output logic             last
);

    assign last = (pos == POS_W'(LINE_PIXELS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (inc) begin
            pos <= last ? '0 : pos + POS_W'(1);
        end
    end

endmodule

// File: rtl/word_unpack.sv
// Splits 32-bit words into a stream of 8-bit pixels, one per cycle.
// Optional line-end flag built with WORD_UNPACK_LINE_CNT_EN.
module word_unpack
    import edge_pkg::*;
#(
    parameter int LINE_PIXELS = 640,
    parameter bit LSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_in,
    output logic              word_ready,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_data,
    input  logic              pix_ready,
    output logic              pix_eol
);

    if ((LINE_PIXELS % PIX_PER_WORD) != 0 || LINE_PIXELS < PIX_PER_WORD) begin : g_bad_cfg
        $error("LINE_PIXELS must be a multiple of 4 and >= 4");
    end

    unpack_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_idx;
    logic              pix_xfer;
    logic              word_xfer;

    assign last_idx   = (idx_q == IDX_W'(PIX_PER_WORD - 1));
    assign pix_valid  = (state_q == ST_HOLD);
    // Refill path from pix_ready lets the next word land with no bubble.
    assign word_ready = (state_q == ST_EMPTY) || (last_idx && pix_ready);
    assign pix_data   = pick_pix(word_q, idx_q, LSB_FIRST);
    assign pix_xfer   = pix_valid && pix_ready;
    assign word_xfer  = word_valid && word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            ST_EMPTY: begin
                if (word_xfer) begin
                    word_d  = word_in;
                    idx_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pix_xfer) begin
                    if (!last_idx) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (word_xfer) begin
                        word_d = word_in;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
                idx_d   = '0;
            end
        endcase
    end

`ifdef WORD_UNPACK_LINE_CNT_EN
    localparam int POS_W = $clog2(LINE_PIXELS);

    logic [POS_W-1:0] line_pos;
    logic             line_last;

    line_pos_counter #(
        .LINE_PIXELS (LINE_PIXELS),
        .POS_W       (POS_W)
    ) u_line_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pix_xfer),
        .pos   (line_pos),
        .last  (line_last)
    );

    assign pix_eol = pix_valid && line_last;
`else
    assign pix_eol = 1'b0;
`endif

endmodule

// File: tb/tb_word_unpack.sv
// Directed scoreboard bench for word_unpack: LSB- and MSB-first
// instances driven in parallel from one stimulus stream.
module tb_word_unpack;

    localparam int LP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        word_valid;
    logic [31:0] word_in;
    logic        pix_ready;

    logic        wr, pv, pe;
    logic [7:0]  pd;
    logic        wrm, pvm, pem;
    logic [7:0]  pdm;

    logic [7:0]  q[$];
    logic [7:0]  qm[$];
    logic [7:0]  got[$];
    int          pcount;
    int          eol_seen;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    word_unpack #(.LINE_PIXELS(LP), .LSB_FIRST(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_valid (word_valid),
        .word_in    (word_in),
        .word_ready (wr),
        .pix_valid  (pv),
        .pix_data   (pd),
        .pix_ready  (pix_ready),
        .pix_eol    (pe)
    );

    word_unpack #(.LINE_PIXELS(LP), .LSB_FIRST(0)) dut_m (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_valid (word_valid),
        .word_in    (word_in),
        .word_ready (wrm),
        .pix_valid  (pvm),
        .pix_data   (pdm),
        .pix_ready  (pix_ready),
        .pix_eol    (pem)
    );

    task automatic chk(input string tag, input logic [31:0] got_v,
                       input logic [31:0] exp_v);
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step(output logic acc);
        logic exp_eol;
        @(negedge clk);
        chk("pix_valid", 32'(pv), 32'(q.size() != 0));
        chk("word_ready", 32'(wr),
            32'(q.size() == 0 || (q.size() == 1 && pix_ready)));
        chk("m_pix_valid", 32'(pvm), 32'(qm.size() != 0));
        chk("m_word_ready", 32'(wrm),
            32'(qm.size() == 0 || (qm.size() == 1 && pix_ready)));
`ifdef WORD_UNPACK_LINE_CNT_EN
        exp_eol = pv && ((pcount % LP) == LP - 1);
        chk("line_pos", 32'(dut.u_line_pos.pos), 32'(pcount % LP));
`else
        exp_eol = 1'b0;
`endif
        chk("pix_eol", 32'(pe), 32'(exp_eol));
        if (pv && pix_ready && q.size() != 0) begin
            chk("pix_data", 32'(pd), 32'(q[0]));
            got.push_back(pd);
            void'(q.pop_front());
            if (pe) eol_seen++;
            pcount++;
        end
        if (pvm && pix_ready && qm.size() != 0) begin
            chk("m_pix_data", 32'(pdm), 32'(qm[0]));
            void'(qm.pop_front());
        end
        acc = word_valid && wr;
        if (acc) begin
            for (int i = 0; i < 4; i++) begin
                q.push_back(word_in[8*i +: 8]);
                qm.push_back(word_in[8*(3-i) +: 8]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ws [4], input int n);
        logic acc;
        int   k;
        k = 0;
        word_valid = 1'b1;
        word_in = ws[0];
        for (int c = 0; c < 40 && k < n; c++) begin
            step(acc);
            if (acc) begin
                k++;
                if (k < n) word_in = ws[k];
            end
        end
        word_valid = 1'b0;
        chk("send_budget", 32'(k), 32'(n));
    endtask

    task automatic drain();
        logic acc;
        word_valid = 1'b0;
        for (int c = 0; c < 30 && (q.size() != 0 || qm.size() != 0); c++)
            step(acc);
        chk("drain_budget", 32'(q.size() + qm.size()), 32'd0);
        step(acc);
    endtask

    task automatic check_seq(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(tag, 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pix_valid", 32'(pv), 32'd0);
        chk("rst_word_ready", 32'(wr), 32'd1);
        chk("rst_pix_data", 32'(pd), 32'd0);
        chk("rst_pix_eol", 32'(pe), 32'd0);
        chk("rst_m_pix_valid", 32'(pvm), 32'd0);
        q.delete();
        qm.delete();
        got.delete();
        pcount = 0;
        eol_seen = 0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        rst_n = 1'b0;
        word_valid = 1'b0;
        word_in = '0;
        pix_ready = 1'b1;
        pcount = 0;
        eol_seen = 0;
        #12;
        chk("reset_pix_valid", 32'(pv), 32'd0);
        chk("reset_word_ready", 32'(wr), 32'd1);
        chk("reset_pix_data", 32'(pd), 32'd0);
        chk("reset_pix_eol", 32'(pe), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single word, both byte orders
        got.delete();
        send('{32'h44332211, 0, 0, 0}, 1);
        chk("first_pix_latency", 32'(pv), 32'd1);
        chk("first_pix_lsb", 32'(pd), 32'h11);
        chk("first_pix_msb", 32'(pdm), 32'h44);
        drain();
        check_seq("lsb_seq", '{8'h11, 8'h22, 8'h33, 8'h44});

        // back-to-back words, no gap
        got.delete();
        send('{32'h03020100, 32'h07060504, 0, 0}, 2);
        drain();
        check_seq("b2b_seq", '{8'h00, 8'h01, 8'h02, 8'h03,
                                8'h04, 8'h05, 8'h06, 8'h07});

        // stall at index 1 with a new word already offered
        got.delete();
        word_valid = 1'b1;
        word_in = 32'h44332211;
        step(acc);
        chk("stall_accept", 32'(acc), 32'd1);
        word_valid = 1'b0;
        step(acc);
        pix_ready = 1'b0;
        word_valid = 1'b1;
        word_in = 32'h0B0A0908;
        for (int i = 0; i < 5; i++) begin
            step(acc);
            chk("stall_hold", 32'(pd), 32'h22);
            chk("stall_hold_m", 32'(pdm), 32'h33);
            chk("stall_no_accept", 32'(acc), 32'd0);
        end
        pix_ready = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 8 && !acc; c++) step(acc);
        chk("stall_refill", 32'(acc), 32'd1);
        word_valid = 1'b0;
        drain();
        check_seq("stall_seq", '{8'h11, 8'h22, 8'h33, 8'h44,
                                  8'h08, 8'h09, 8'h0A, 8'h0B});

        // line end over three words
        pulse_reset();
        send('{32'h13121110, 32'h17161514, 32'h1B1A1918, 0}, 3);
        drain();
`ifdef WORD_UNPACK_LINE_CNT_EN
        chk("eol_count", 32'(eol_seen), 32'd1);
`else
        chk("eol_count", 32'(eol_seen), 32'd0);
`endif
        chk("line_pixels", 32'(pcount), 32'd12);

        // reset in the middle of a word
        got.delete();
        word_valid = 1'b1;
        word_in = 32'h44332211;
        step(acc);
        word_valid = 1'b0;
        step(acc);
        step(acc);
        chk("pre_rst_idx2", 32'(pd), 32'h33);
        pulse_reset();
        for (int i = 0; i < 3; i++) step(acc);
        chk("post_rst_idle", 32'(got.size()), 32'd0);
        send('{32'hDDCCBBAA, 0, 0, 0}, 1);
        drain();
        check_seq("post_rst_seq", '{8'hAA, 8'hBB, 8'hCC, 8'hDD});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_unpack.md
WORD_UNPACK -- requirements
Module: word_unpack

Interface
REQ-001 The block SHALL have parameter LINE_PIXELS, default 640, meaning pixels per image line (multiple of 4, >= 4).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, meaning 1 = byte [7:0] emitted first, 0 = byte [31:24] emitted first.
REQ-003 The block SHALL have port clk  input  1  meaning single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-005 The block SHALL have port word_valid  input  1  meaning 32-bit word offered by the upstream shift chain.
REQ-006 The block SHALL have port word_in  input  32  meaning packed word of four 8-bit pixels.
REQ-007 The block SHALL have port word_ready  output  1  meaning the block accepts word_in this cycle.
REQ-008 The block SHALL have port pix_valid  output  1  meaning pix_data is valid.
REQ-009 The block SHALL have port pix_data  output  8  meaning current pixel.
REQ-010 The block SHALL have port pix_ready  input  1  meaning downstream accepts the pixel.
REQ-011 The block SHALL have port pix_eol  output  1  meaning current pixel is last of line (line-count build only, else tied 0).

Function
REQ-012 Word transfer SHALL occur on a rising edge where word_valid && word_ready; pixel transfer SHALL occur where pix_valid && pix_ready.
REQ-013 The block SHALL implement two states: EMPTY (no word held) and HOLD (word held, byte index 0..3).
REQ-014 In EMPTY, word_ready SHALL be 1 and pix_valid 0; a word transfer SHALL capture word_in, set byte index 0, go to HOLD.
REQ-015 In HOLD, pix_valid SHALL be 1 and pix_data SHALL be the byte selected by index and LSB_FIRST; a pixel transfer SHALL increment the index.
REQ-016 In HOLD, word_ready SHALL be 1 only when index = 3 and pix_ready = 1 (combinational path from pix_ready, no bubble).
REQ-017 On pixel transfer at index 3: with a simultaneous word transfer SHALL load the new word at index 0 and stay in HOLD; without one SHALL go to EMPTY.
REQ-018 Latency SHALL be one cycle: word accepted at edge N gives pix_valid = 1 after edge N; sustained throughput SHALL be one pixel per cycle.
REQ-019 pix_data and the held word SHALL remain stable while pix_valid && !pix_ready.
REQ-020 word_ready SHALL never depend on word_valid.

Reset
REQ-021 While rst_n = 0: state EMPTY, index 0, held word 0, pix_valid 0, pix_data 0, pix_eol 0, line position 0; word_ready SHALL read 1.
REQ-022 Reset asserted mid-word SHALL discard the held word and remaining bytes; no pixel is emitted after release until a new word is accepted.

Configuration
REQ-023 With macro WORD_UNPACK_LINE_CNT_EN defined, a line-position counter of width $clog2(LINE_PIXELS) SHALL count pixel transfers, pix_eol SHALL be 1 when pix_valid && position = LINE_PIXELS-1, and the counter SHALL wrap to 0 on that transfer.
REQ-024 Without WORD_UNPACK_LINE_CNT_EN, no counter SHALL be built and pix_eol SHALL be constant 0.

Structure
REQ-025 Shared package edge_pkg SHALL hold PIX_W = 8, WORD_W = 32, PIX_PER_WORD = 4 and the unpack state enum.
REQ-026 The line-position counter SHALL be a sub-module line_pos_counter (inputs clk, rst_n, inc; outputs pos, last), instantiated only under WORD_UNPACK_LINE_CNT_EN.

Verification
REQ-027 The bench SHALL check: word 0x44332211, LSB_FIRST=1, pix_ready=1 -> pix_data 0x11,0x22,0x33,0x44 on four consecutive cycles, first one cycle after acceptance.
REQ-028 The bench SHALL check: same word, LSB_FIRST=0 -> 0x44,0x33,0x22,0x11.
REQ-029 The bench SHALL check: back-to-back words 0x03020100, 0x07060504 with word_valid held 1 -> pixels 0x00..0x07 with no gap; word_ready high only in cycles at index 3.
REQ-030 The bench SHALL check: pix_ready = 0 for 5 cycles at index 1 -> pix_data held at 0x22, word_ready 0, no byte lost on resume.
REQ-031 The bench SHALL check: LINE_PIXELS=8, macro defined, 3 words streamed -> pix_eol on 8th pixel only, position wraps to 0, 9th pixel pix_eol 0.
REQ-032 The bench SHALL check: rst_n pulsed low at index 2 -> pix_valid 0 immediately, after release word_ready 1 and next pixel is byte 0 of next accepted word.
